// File: rtl/audio_frame_serializer.sv
// Buffers each new processed sample (detected by a change of bank index) and streams it as mono I2S.
// Latency: a sample entering an empty FIFO is sent after the next frame wrap; no backpressure, so a full FIFO drops the sample and raises o_overflow.
module audio_frame_serializer #(
  parameter int DEPTH    = 16,
  parameter int BCLK_DIV = 16,
  parameter int SAMPLE_W = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_W-1:0]       i_sample,
  input  logic [3:0]                i_idx,
  input  logic                      i_clear_flags,
  output logic                      o_bclk,
  output logic                      o_lrclk,
  output logic                      o_sdata,
  output logic [$clog2(DEPTH):0]    o_fifo_level,
  output logic                      o_overflow,
  output logic                      o_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  logic [DW-1:0]       div_cnt;
  logic [5:0]          bit_cnt;
  logic [SAMPLE_W-1:0] frame_reg;
  logic [3:0]          prev_idx;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [SAMPLE_W-1:0] mem [DEPTH];

  logic        div_wrap;
  logic        fall;
  logic [5:0]  nxt_bit;
  logic        push;
  logic        pop;
  logic        push_ok;
  logic        pop_ok;
  logic [31:0] slot_word;
  logic        slot_bit;

  always_comb begin
    div_wrap  = (div_cnt == DW'(BCLK_DIV - 1));
    fall      = div_wrap && o_bclk;
    nxt_bit   = bit_cnt + 6'd1;
    push      = (i_idx != prev_idx);
    pop       = fall && (bit_cnt == 6'd63);
    pop_ok    = pop && (o_fifo_level != '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push_ok   = push && ((o_fifo_level != LW'(DEPTH)) || pop_ok);
    // Sample MSB sits at bit 30 so slot position p maps to bit 31-p; p=0 is the I2S delay bit.
    slot_word = 32'(frame_reg) << (31 - SAMPLE_W);
    slot_bit  = slot_word[~nxt_bit[4:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_reg    <= '0;
      prev_idx     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_bclk       <= 1'b0;
      o_lrclk      <= 1'b0;
      o_sdata      <= 1'b0;
      o_fifo_level <= '0;
      o_overflow   <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      prev_idx <= i_idx;

      if (div_wrap) begin
        div_cnt <= '0;
        o_bclk  <= ~o_bclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end

      if (fall) begin
        bit_cnt <= nxt_bit;
        o_lrclk <= nxt_bit[5];
        o_sdata <= slot_bit;
      end

      if (pop) begin
        if (pop_ok) begin
          frame_reg <= mem[rd_ptr];
          rd_ptr    <= rd_ptr + AW'(1);
        end else begin
          frame_reg <= '0;
        end
      end

      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      o_fifo_level <= o_fifo_level + LW'(push_ok) - LW'(pop_ok);

      // Set events are applied after the clear so they win a same-cycle collision.
      if (i_clear_flags) begin
        o_overflow  <= 1'b0;
        o_underflow <= 1'b0;
      end
      if (push && !push_ok) o_overflow  <= 1'b1;
      if (pop && !pop_ok)   o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_frame_serializer.sv
// Directed bench for audio_frame_serializer with DEPTH=4, BCLK_DIV=2 (frame = 256 clk cycles).
module tb_audio_frame_serializer;
  localparam int DEPTH    = 4;
  localparam int BCLK_DIV = 2;
  localparam int SW       = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] i_sample;
  logic [3:0]    i_idx;
  logic          i_clear_flags;
  logic          o_bclk;
  logic          o_lrclk;
  logic          o_sdata;
  logic [2:0]    o_fifo_level;
  logic          o_overflow;
  logic          o_underflow;

  int e;
  int n_checks = 0;
  int n_pass   = 0;

  audio_frame_serializer #(.DEPTH(DEPTH), .BCLK_DIV(BCLK_DIV), .SAMPLE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_sample     (i_sample),
    .i_idx        (i_idx),
    .i_clear_flags(i_clear_flags),
    .o_bclk       (o_bclk),
    .o_lrclk      (o_lrclk),
    .o_sdata      (o_sdata),
    .o_fifo_level (o_fifo_level),
    .o_overflow   (o_overflow),
    .o_underflow  (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  // Collects slot positions 1..24 of the given half of the frame that starts at edge w0.
  task automatic get_word(input int w0, input int half, output logic [23:0] word);
    word = '0;
    for (int k = 1; k <= 24; k++) begin
      run_to(w0 + half * 128 + 4 * k);
      word[24 - k] = o_sdata;
    end
  endtask

  logic [23:0] samp;
  logic [23:0] w;
  int          max_lvl;
  int          pos;
  logic [23:0] exp_w [4] = '{24'h222222, 24'h333333, 24'h444444, 24'h777777};
  int          exp_l [4] = '{3, 2, 1, 0};

  initial begin
    reset = 1'b1; i_idx = '0; i_sample = '0; i_clear_flags = 1'b0; e = 0;
    repeat (3) step();
    check("rst_bclk",  o_bclk, 0);
    check("rst_lrclk", o_lrclk, 0);
    check("rst_sdata", o_sdata, 0);
    check("rst_level", o_fifo_level, 0);
    check("rst_ovf",   o_overflow, 0);
    check("rst_unf",   o_underflow, 0);

    // Idle first frame: bclk toggles every 2 edges, lrclk flips at edge 128.
    reset = 1'b0; e = 0;
    for (int i = 1; i < 256; i++) begin
      step();
      check("idle_bclk",  o_bclk, (e / 2) % 2);
      check("idle_lrclk", o_lrclk, (e / 4) >= 32);
      check("idle_sdata", o_sdata, 0);
      check("idle_unf",   o_underflow, 0);
    end
    step();
    check("wrap1_unf",   o_underflow, 1);
    check("wrap1_lrclk", o_lrclk, 0);
    check("wrap1_level", o_fifo_level, 0);

    // Single push, then clear the underflow flag.
    i_idx = 4'd1; i_sample = 24'hA55A0F;
    step();
    check("push1_level", o_fifo_level, 1);
    i_sample = 24'h123456; i_clear_flags = 1'b1;
    step();
    i_clear_flags = 1'b0;
    check("clr_unf", o_underflow, 0);
    run_to(512);
    check("pop1_level", o_fifo_level, 0);
    check("pop1_unf",   o_underflow, 0);
    samp = 24'hA55A0F;
    for (int n = 0; n < 64; n++) begin
      run_to(512 + 4 * n);
      pos = n % 32;
      check("push1_sdata", o_sdata, (pos >= 1 && pos <= 24) ? samp[24 - pos] : 1'b0);
      check("push1_lrclk", o_lrclk, n >= 32);
    end
    run_to(768);
    check("wrap3_unf", o_underflow, 1);

    // Constant idx with a changing sample: one push only (C30001 at the 1->3 change).
    run_to(770);
    i_idx = 4'd3; i_sample = 24'hC30001; max_lvl = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (int'(o_fifo_level) > max_lvl) max_lvl = int'(o_fifo_level);
      if (e == 771)  check("const_level_push", o_fifo_level, 1);
      if (e == 1024) check("const_level_pop",  o_fifo_level, 0);
      if (e == 1028) check("const_bit23", o_sdata, 1);
      if (e == 1036) check("const_bit21", o_sdata, 0);
      if (e == 1120) check("const_bit0",  o_sdata, 1);
      if (e == 1124) check("const_pad",   o_sdata, 0);
      i_sample = 24'(e * 37 + 5);
    end
    check("const_max_level", max_lvl, 1);

    // Six pushes in one frame into a 4-deep FIFO.
    run_to(1800);
    for (int k = 1; k <= 6; k++) begin
      i_idx = 4'(k); i_sample = 24'(24'h111111 * k);
      step();
      check("ovf_level", o_fifo_level, (k < 4) ? k : 4);
      check("ovf_flag",  o_overflow, k >= 5);
    end
    run_to(1900);
    i_clear_flags = 1'b1;
    step();
    i_clear_flags = 1'b0;
    check("clr_ovf", o_overflow, 0);

    // Push while full in the wrap cycle.
    run_to(2047);
    i_idx = 4'd7; i_sample = 24'h777777;
    step();
    check("full_wrap_level", o_fifo_level, 4);
    check("full_wrap_ovf",   o_overflow, 0);
    get_word(2048, 0, w);
    check("word_s1_left", w, 24'h111111);
    get_word(2048, 1, w);
    check("word_s1_right", w, 24'h111111);
    for (int f = 0; f < 4; f++) begin
      run_to(2304 + 256 * f);
      check("order_level", o_fifo_level, exp_l[f]);
      get_word(2304 + 256 * f, 0, w);
      check("order_word", w, exp_w[f]);
    end

    // Clear colliding with an underflow event: the set wins.
    run_to(3100);
    i_clear_flags = 1'b1;
    step();
    i_clear_flags = 1'b0;
    check("clr_unf2", o_underflow, 0);
    run_to(3327);
    i_clear_flags = 1'b1;
    step();
    i_clear_flags = 1'b0;
    check("clr_vs_unf", o_underflow, 1);

    // Reset mid-frame at bit_cnt=40 with three samples queued.
    run_to(3330);
    for (int k = 8; k <= 10; k++) begin
      i_idx = 4'(k); i_sample = 24'(24'h010101 * k);
      step();
    end
    run_to(3488);
    check("mid_level",  o_fifo_level, 3);
    check("mid_lrclk",  o_lrclk, 1);
    reset = 1'b1; i_idx = '0;
    step();
    check("mid_rst_bclk",  o_bclk, 0);
    check("mid_rst_lrclk", o_lrclk, 0);
    check("mid_rst_sdata", o_sdata, 0);
    check("mid_rst_level", o_fifo_level, 0);
    check("mid_rst_ovf",   o_overflow, 0);
    check("mid_rst_unf",   o_underflow, 0);

    // After reset the FIFO is empty; push into it exactly at the wrap.
    reset = 1'b0; e = 0;
    run_to(255);
    check("post_rst_level", o_fifo_level, 0);
    check("post_rst_unf",   o_underflow, 0);
    i_idx = 4'd5; i_sample = 24'h0F0F0F;
    step();
    check("empty_wrap_unf",   o_underflow, 1);
    check("empty_wrap_level", o_fifo_level, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/audio_frame_serializer.md
Name: audio_frame_serializer

Overview:
- Downstream consumer of the synthesizer's processed-sample output: the 24-bit signal word plus its 4-bit bank index.
- Detects each new sample, buffers it in a small FIFO, and serializes it as an I2S-format mono stream (same sample on left and right) toward the DAC.
- All serial clocks are derived from the single system clock through internal dividers. No second clock domain exists.

Parameters:
- DEPTH, 16: FIFO depth in samples. Must be a power of 2, ≥2.
- BCLK_DIV, 16: clk cycles per o_bclk half-period. Must be ≥1.
- SAMPLE_W, 24: sample width. Must be ≤31.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_sample  in  SAMPLE_W  processed sample from bank manager (two's complement)
- i_idx  in  4  bank index accompanying i_sample
- i_clear_flags  in  1  one-cycle pulse that clears the sticky flags
- o_bclk  out  1  serial bit clock
- o_lrclk  out  1  word select: 0 = left, 1 = right
- o_sdata  out  1  serial data, MSB first, changes on o_bclk falling edge
- o_fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full
- o_underflow  out  1  sticky: a frame was loaded while the FIFO was empty

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - o_bclk = 0, o_lrclk = 0, o_sdata = 0, o_fifo_level = 0, o_overflow = 0, o_underflow = 0.
  - Internal state: div_cnt = 0, bit_cnt = 0, frame_reg = 0, prev_idx = 0, FIFO pointers = 0.
- Reset mid-frame aborts the frame immediately and discards FIFO contents.
- Capture:
  - Register i_idx into prev_idx every cycle.
  - A push request occurs in any cycle where i_idx != prev_idx. i_sample is written in that same cycle.
  - A constant idx produces no pushes, so no duplicate samples are captured.
- Bit-clock divider:
  - div_cnt counts 0..BCLK_DIV-1.
  - At BCLK_DIV-1, div_cnt returns to 0 and o_bclk toggles.
- Falling toggle (o_bclk 1→0):
  - bit_cnt (6 bits) increments modulo 64.
  - o_lrclk = new bit_cnt[5].
  - o_sdata is updated per the slot mapping below.
- Slot mapping, with pos = bit_cnt[4:0]:
  - pos 0: o_sdata = 0 (I2S one-bit delay).
  - pos 1..SAMPLE_W: o_sdata = frame_reg[SAMPLE_W-pos].
  - pos > SAMPLE_W: o_sdata = 0.
  - The same frame_reg is sent in both halves.
- Pop:
  - A pop request occurs on the falling toggle where bit_cnt wraps 63→0.
  - If the pre-cycle level > 0: frame_reg ← FIFO head and the level decrements.
  - Otherwise: frame_reg ← 0 and o_underflow is set.
  - The first frame after reset transmits zeros, and o_underflow stays 0 until the first wrap.
- Simultaneous push and pop in one cycle:
  - Pop is evaluated on the pre-cycle level.
  - Push is accepted if the level < DEPTH or a pop occurs that cycle.
  - Push and pop both accepted: level unchanged.
  - Push with empty FIFO at pop time: underflow is set, zeros are loaded, and the push is stored.
- Overflow: a push with level == DEPTH and no simultaneous pop drops the sample, sets o_overflow, and leaves the FIFO unchanged.
- Sticky flags: i_clear_flags clears both flags. If a set event occurs in the same cycle as a clear, the set wins.
- Pointers wrap modulo DEPTH. o_fifo_level ranges over 0..DEPTH.
- Timing: one frame = 128·BCLK_DIV clk cycles. A sample pushed into an empty FIFO is transmitted starting at the next 63→0 wrap.
- Sample MSB first appears on o_sdata (left channel) one bclk period after the wrap, i.e. 2·BCLK_DIV clk cycles after the pop.

Test Plan:
- Reset with BCLK_DIV=2 and idle idx:
  - o_bclk toggles every 2 clk cycles; o_lrclk toggles every 32 bclk periods (128 clk cycles).
  - o_sdata stays 0; both flags stay 0 until the first wrap.
  - After the first wrap, o_underflow = 1.
- Single push: i_idx 0→1 with i_sample=24'hA5_5A_0F.
  - o_fifo_level becomes 1, then 0 at the next wrap.
  - The following left and right slots both serialize 0 followed by A55A0F MSB first, then 7 zero bits.
- Constant idx: hold i_idx=3 for 1000 cycles with i_sample changing.
  - Exactly one push occurs (on the 1→3 change); o_fifo_level never exceeds 1.
- Overflow with DEPTH=4: push 6 distinct samples (idx 1..6) within one frame.
  - o_fifo_level = 4 and o_overflow = 1.
  - Serialized order is samples 1, 2, 3, 4; samples 5 and 6 are lost.
- Simultaneous events:
  - Push while full in the wrap cycle: accepted, level stays 4, o_overflow not set.
  - i_clear_flags in the same cycle as an underflow event: o_underflow remains 1.
- Reset mid-frame (bit_cnt=40, level=3): the next cycle shows all outputs at reset values and o_fifo_level = 0.
